// File: rtl/serial_paralelo.sv
// -----------------------------------------------------------------------------
// serial_paralelo
//   Receive end of the serial link. Shifts in a 1-bit MSB-first stream on
//   clk32_f, finds the byte boundary on the COMMA symbol the transmitter sends
//   while idle, declares the link active after NUM_COMMA consecutive aligned
//   commas, and then delivers non-comma bytes with a valid flag.
//
// Ports:
//   clk32_f    in   serial bit clock, one bit per rising edge
//   reset_L    in   synchronous active-low reset
//   data_in    in   serial bit stream, MSB of each byte first
//   data_out   out  [7:0] recovered data byte, held between byte boundaries
//   valid_out  out  data_out holds a non-comma byte received while active
//   active     out  byte alignment locked (sticky until reset)
//   byte_tick  out  one-cycle strobe on the edge that completes a byte
// -----------------------------------------------------------------------------
module serial_paralelo #(
    parameter logic [7:0]  COMMA     = 8'hBC,
    parameter int unsigned NUM_COMMA = 4
) (
    input  logic       clk32_f,
    input  logic       reset_L,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       byte_tick
);

    localparam logic [3:0] NUM_C = 4'(NUM_COMMA);

    typedef enum logic [1:0] {
        SEARCH,
        ALIGN,
        ACTIVE
    } state_t;

    state_t     state, state_nx;
    logic [7:0] sr;
    logic [7:0] nxt;
    logic [2:0] bit_cnt, bit_cnt_nx;
    logic [3:0] comma_cnt, comma_cnt_nx;
    logic [7:0] data_nx;
    logic       valid_nx;
    logic       active_nx;
    logic       tick_nx;
    logic       is_comma;
    logic       boundary;

    // The byte as it will look after this edge, including the bit sampled now.
    // All decisions use it so outputs update on the edge that takes the LSB.
    assign nxt      = {sr[6:0], data_in};
    assign is_comma = (nxt == COMMA);
    assign boundary = (bit_cnt == 3'd7);

    // NOTE: every variable gets a default before the case statement, so no
    //       path through the block leaves one unassigned and no latch appears.
    always_comb begin
        state_nx     = state;
        bit_cnt_nx   = bit_cnt + 3'd1;   // wraps 7 -> 0 on the boundary edge
        comma_cnt_nx = comma_cnt;
        data_nx      = data_out;
        valid_nx     = valid_out;
        active_nx    = active;
        tick_nx      = 1'b0;

        case (state)
            SEARCH: begin
                // Bit-by-bit hunt: any window equal to COMMA fixes the boundary.
                bit_cnt_nx = 3'd0;
                if (is_comma) begin
                    comma_cnt_nx = 4'd1;
                    tick_nx      = 1'b1;
                    if (NUM_C == 4'd1) begin
                        state_nx  = ACTIVE;
                        active_nx = 1'b1;
                    end else begin
                        state_nx = ALIGN;
                    end
                end
            end

            ALIGN: begin
                if (boundary) begin
                    tick_nx = 1'b1;
                    if (is_comma) begin
                        comma_cnt_nx = comma_cnt + 4'd1;
                        if (comma_cnt_nx == NUM_C) begin
                            state_nx  = ACTIVE;
                            active_nx = 1'b1;
                        end
                    end else begin
                        // Lost the run of commas: restart the bit-level search.
                        state_nx     = SEARCH;
                        comma_cnt_nx = 4'd0;
                    end
                end
            end

            ACTIVE: begin
                // comma_cnt is left saturated at NUM_COMMA; only reset leaves here.
                if (boundary) begin
                    tick_nx = 1'b1;
                    if (is_comma) begin
                        valid_nx = 1'b0;
                    end else begin
                        data_nx  = nxt;
                        valid_nx = 1'b1;
                    end
                end
            end

            default: begin
                state_nx = SEARCH;
            end
        endcase
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch and is
    //       only seen on a rising edge of clk32_f.
    // NOTE: state registers use non-blocking assignments so every flop samples
    //       the pre-edge values regardless of statement order.
    always_ff @(posedge clk32_f) begin
        if (!reset_L) begin
            state     <= SEARCH;
            sr        <= 8'h00;
            bit_cnt   <= 3'd0;
            comma_cnt <= 4'd0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            active    <= 1'b0;
            byte_tick <= 1'b0;
        end else begin
            state     <= state_nx;
            sr        <= nxt;
            bit_cnt   <= bit_cnt_nx;
            comma_cnt <= comma_cnt_nx;
            data_out  <= data_nx;
            valid_out <= valid_nx;
            active    <= active_nx;
            byte_tick <= tick_nx;
        end
    end

endmodule
